// File: rtl/ow_seq.sv
// ---------------------------------------------------------------------------
// ow_seq - byte-level sequencer for the bit-level 1-wire master.
//
// Accepts one command per valid/ready handshake (bus reset, write byte,
// read byte, ROM-search triplet), splits it into single-slot start pulses
// towards the 1-wire master, gathers read bits / presence and returns one
// response per command on a valid/ready response channel.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cmd_valid_i/ready_o   command handshake
//   cmd_op_i              0=RESET 1=WRITE_BYTE 2=READ_BYTE 3=TRIPLET
//   cmd_addr_i            target bus select
//   cmd_data_i            byte to write (WRITE_BYTE)
//   cmd_dir_i             search direction for TRIPLET discrepancies
//   rsp_valid_o/ready_i   response handshake
//   rsp_data_o            read byte or {5'b0, dir_taken, cmp, id}
//   rsp_presence_o        presence result of RESET
//   busy_o                command in progress or response pending
//   owm_*                 single-slot interface to the 1-wire master
// ---------------------------------------------------------------------------
module ow_seq #(
    parameter int OW_ADDR_W = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [OW_ADDR_W-1:0] cmd_addr_i,
    input  logic [7:0]           cmd_data_i,
    input  logic                 cmd_dir_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [7:0]           rsp_data_o,
    output logic                 rsp_presence_o,
    output logic                 busy_o,
    output logic                 owm_start_o,
    output logic [2:0]           owm_cmd_o,
    output logic [OW_ADDR_W-1:0] owm_addr_o,
    output logic                 owm_wrdat_o,
    input  logic                 owm_rddat_i,
    input  logic                 owm_presence_i,
    input  logic                 owm_ready_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    localparam logic [2:0] SLOT_NONE = 3'b000;
    localparam logic [2:0] SLOT_RST  = 3'b001;
    localparam logic [2:0] SLOT_WR   = 3'b010;
    localparam logic [2:0] SLOT_RD   = 3'b100;

    // Triplet phases: read id bit, read complement bit, write chosen direction
    localparam logic [1:0] PH_ID  = 2'd0;
    localparam logic [1:0] PH_CMP = 2'd1;
    localparam logic [1:0] PH_WR  = 2'd2;

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [OW_ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]             sh_q, sh_d;
    logic                   dir_q, dir_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [1:0]             ph_q, ph_d;
    logic                   id_q, id_d;
    logic                   cmp_q, cmp_d;
    logic                   taken_q, taken_d;
    logic [7:0]             rsp_data_q, rsp_data_d;
    logic                   rsp_pres_q, rsp_pres_d;
    logic [2:0]             owm_cmd_q, owm_cmd_d;
    logic                   owm_wrdat_q, owm_wrdat_d;
    logic                   cmd_ready_q;
    logic                   rsp_valid_q;
    logic                   busy_q;
    logic                   start_s;
    logic                   taken_s;

    // Next-state, datapath and slot-descriptor decode
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        sh_d        = sh_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        ph_d        = ph_q;
        id_d        = id_q;
        cmp_d       = cmp_q;
        taken_d     = taken_q;
        rsp_data_d  = rsp_data_q;
        rsp_pres_d  = rsp_pres_q;
        owm_cmd_d   = owm_cmd_q;
        owm_wrdat_d = owm_wrdat_q;
        start_s     = 1'b0;
        // Direction actually written: the bit the devices agree on, or the
        // requested direction when both values are present on the bus.
        taken_s     = (id_q != owm_rddat_i) ? id_q : dir_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    op_d    = cmd_op_i;
                    addr_d  = cmd_addr_i;
                    sh_d    = cmd_data_i;
                    dir_d   = cmd_dir_i;
                    cnt_d   = 3'd0;
                    ph_d    = PH_ID;
                    id_d    = 1'b0;
                    cmp_d   = 1'b0;
                    taken_d = 1'b0;
                    state_d = ISSUE;
                    case (cmd_op_i)
                        OP_RESET: begin
                            owm_cmd_d   = SLOT_RST;
                            owm_wrdat_d = 1'b0;
                        end
                        OP_WRITE: begin
                            owm_cmd_d   = SLOT_WR;
                            owm_wrdat_d = cmd_data_i[0];
                        end
                        default: begin
                            owm_cmd_d   = SLOT_RD;
                            owm_wrdat_d = 1'b0;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end

            ISSUE: begin
                if (owm_ready_i) begin
                    start_s = 1'b1;
                    state_d = WAIT;
                end else begin
                    state_d = ISSUE;
                end
            end

            WAIT: begin
                // Master drops ready after the start; its return marks completion
                if (owm_ready_i) begin
                    case (op_q)
                        OP_RESET: begin
                            rsp_pres_d = owm_presence_i;
                            rsp_data_d = 8'h00;
                            owm_cmd_d  = SLOT_NONE;
                            state_d    = RESP;
                        end
                        OP_WRITE: begin
                            sh_d  = {1'b0, sh_q[7:1]};
                            cnt_d = cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                rsp_data_d  = 8'h00;
                                owm_cmd_d   = SLOT_NONE;
                                owm_wrdat_d = 1'b0;
                                state_d     = RESP;
                            end else begin
                                owm_wrdat_d = sh_q[1];
                                state_d     = ISSUE;
                            end
                        end
                        OP_READ: begin
                            sh_d  = {owm_rddat_i, sh_q[7:1]};
                            cnt_d = cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                rsp_data_d = {owm_rddat_i, sh_q[7:1]};
                                owm_cmd_d  = SLOT_NONE;
                                state_d    = RESP;
                            end else begin
                                state_d = ISSUE;
                            end
                        end
                        default: begin
                            case (ph_q)
                                PH_ID: begin
                                    id_d    = owm_rddat_i;
                                    ph_d    = PH_CMP;
                                    state_d = ISSUE;
                                end
                                PH_CMP: begin
                                    cmp_d = owm_rddat_i;
                                    if (id_q && owm_rddat_i) begin
                                        // No device answered: report without a write slot
                                        taken_d    = 1'b1;
                                        rsp_data_d = {5'b00000, 1'b1, 1'b1, 1'b1};
                                        owm_cmd_d  = SLOT_NONE;
                                        state_d    = RESP;
                                    end else begin
                                        taken_d     = taken_s;
                                        ph_d        = PH_WR;
                                        owm_cmd_d   = SLOT_WR;
                                        owm_wrdat_d = taken_s;
                                        state_d     = ISSUE;
                                    end
                                end
                                default: begin
                                    rsp_data_d  = {5'b00000, taken_q, cmp_q, id_q};
                                    owm_cmd_d   = SLOT_NONE;
                                    owm_wrdat_d = 1'b0;
                                    state_d     = RESP;
                                end
                            endcase
                        end
                    endcase
                end else begin
                    state_d = WAIT;
                end
            end

            RESP: begin
                if (rsp_valid_q && rsp_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs registered from next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            op_q        <= 2'd0;
            addr_q      <= '0;
            sh_q        <= 8'h00;
            dir_q       <= 1'b0;
            cnt_q       <= 3'd0;
            ph_q        <= PH_ID;
            id_q        <= 1'b0;
            cmp_q       <= 1'b0;
            taken_q     <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_pres_q  <= 1'b0;
            owm_cmd_q   <= SLOT_NONE;
            owm_wrdat_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            sh_q        <= sh_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
            id_q        <= id_d;
            cmp_q       <= cmp_d;
            taken_q     <= taken_d;
            rsp_data_q  <= rsp_data_d;
            rsp_pres_q  <= rsp_pres_d;
            owm_cmd_q   <= owm_cmd_d;
            owm_wrdat_q <= owm_wrdat_d;
            cmd_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign cmd_ready_o    = cmd_ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_presence_o = rsp_pres_q;
    assign busy_o         = busy_q;
    // Start must reach the master in the same cycle it reports ready
    assign owm_start_o    = start_s;
    assign owm_cmd_o      = owm_cmd_q;
    assign owm_addr_o     = addr_q;
    assign owm_wrdat_o    = owm_wrdat_q;

endmodule
